datapath_seq: RTL and testbench
===============================

DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the register, bus and ALU operand width in bits.
REQ-002 The block SHALL have parameter NREGS, default 16, giving the general-register count (power of two, 2..32); AW = clog2(NREGS).
REQ-003 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port clear, input, 1: reset, synchronous, active-low.
REQ-005 Port start, input, 1: request one operation; sampled only in IDLE.
REQ-006 Port op, input, 4: opcode. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 MUL; 12-15 illegal.
REQ-007 Ports ra, rb, rc, input, AW each: destination, first source and second source register indices.
REQ-008 Ports ld_en (1), ld_addr (AW), ld_data (WIDTH), input: external register load.
REQ-009 Port rd_addr input AW; port rd_data output WIDTH: combinational readback of R[rd_addr].
REQ-010 Ports busy (1), done (1), err (1), zero (1), hi (WIDTH), lo (WIDTH), output: status and HI/LO registers.

Function
REQ-011 The sequencer SHALL use states IDLE, TY, TZ, TWB, TWBHI.
REQ-012 In IDLE with start=1 and op legal, the next state SHALL be TY; opcodes 12-15 SHALL instead pulse err for one cycle and stay in IDLE.
REQ-013 On acceptance, op, ra, rb and rc SHALL be captured; later input changes SHALL have no effect.
REQ-014 TY: bus = R[rb]; Y <= bus; next TZ.
REQ-015 TZ: bus = R[rc]; Z (2*WIDTH) <= ALU(Y, bus); next TWBHI for MUL, else TWB.
REQ-016 Arithmetic: ADD/SUB modulo 2^WIDTH. Shifts and rotates use the low clog2(WIDTH) bits of the bus as the amount. SHRA sign-fills. NEG and NOT act on the bus only, ignoring Y. MUL is a signed WIDTH x WIDTH product into the full Z.
REQ-017 TWB: R[ra] <= Z[WIDTH-1:0]; zero <= (Z[WIDTH-1:0]==0); done=1 for this cycle; next IDLE.
REQ-018 TWBHI: hi <= Z[2W-1:W]; lo <= Z[W-1:0]; zero <= (Z==0); no general-register write; done=1; next IDLE.
REQ-019 Latency from the start-accepted edge to done SHALL be 3 cycles for non-MUL opcodes and 3 cycles for MUL.
REQ-020 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored, neither queued nor flagged.
REQ-021 ld_en SHALL write R[ld_addr] <= ld_data only in IDLE and SHALL be ignored while busy.
REQ-022 ld_en and start in the same IDLE cycle SHALL both take effect; the operation SHALL see the loaded value.
REQ-023 If ra equals rb or rc, sources SHALL be read before the TWB write, so in-place updates are correct.
REQ-024 R0 SHALL be an ordinary writable register.

Reset
REQ-025 clear=0 at a rising edge SHALL set state IDLE, clear all R[i], Y, Z, hi and lo to 0, and clear busy, done, err and zero to 0, overriding ld_en and start.
REQ-026 clear asserted mid-operation SHALL abort the operation with no register write; the next cycle is IDLE.

Configuration
REQ-027 With macro DATAPATH_SEQ_MUL_EN defined, opcode 11 SHALL execute per REQ-015/018; undefined, opcode 11 SHALL be illegal per REQ-012, and the multiplier and TWBHI SHALL be absent.

Verification
REQ-028 Load R1=5, R2=7; ADD ra=3 rb=1 rc=2 -> done 3 cycles after start, R3=12, zero=0.
REQ-029 R1=0x80000000, R2=4; SHRA ra=4 -> R4=0xF8000000; ROL ra=5 -> R5=0x00000008.
REQ-030 R1=-3, R2=6, MUL with DATAPATH_SEQ_MUL_EN -> hi=0xFFFFFFFF, lo=0xFFFFFFEE, no R write; without the macro -> err pulse, busy stays 0.
REQ-031 start held 1 and ld_en=1 while busy -> exactly one operation completes, target of ld unchanged.
REQ-032 clear=0 in TZ of SUB ra=6 -> R6 unchanged (0), busy=0 next cycle; new start then completes normally.
REQ-033 op=13 -> single-cycle err, no state change; SUB ra=1 rb=1 rc=1 -> R1=0, zero=1.

Source files
------------

// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : datapath_seq
// Brief    : Register file + ALU driven by an IDLE/TY/TZ/TWB(/TWBHI) sequencer.
//            Define DATAPATH_SEQ_MUL_EN to add the signed multiplier (op 11).
// Revision : 1.0 - initial release
// ============================================================================
module datapath_seq #(
  parameter int  WIDTH = 32,
  parameter int  NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rc,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef DATAPATH_SEQ_MUL_EN
  localparam int c_ZW = 2 * WIDTH;
`else
  // Without the multiplier the upper half of Z would always be zero.
  localparam int c_ZW = WIDTH;
`endif

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_AND  = 4'd2;
  localparam logic [3:0] c_OP_OR   = 4'd3;
  localparam logic [3:0] c_OP_SHR  = 4'd4;
  localparam logic [3:0] c_OP_SHRA = 4'd5;
  localparam logic [3:0] c_OP_SHL  = 4'd6;
  localparam logic [3:0] c_OP_ROR  = 4'd7;
  localparam logic [3:0] c_OP_ROL  = 4'd8;
  localparam logic [3:0] c_OP_NEG  = 4'd9;
  localparam logic [3:0] c_OP_NOT  = 4'd10;
`ifdef DATAPATH_SEQ_MUL_EN
  localparam logic [3:0] c_OP_MUL  = 4'd11;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TY    = 3'd1,
    S_TZ    = 3'd2,
`ifdef DATAPATH_SEQ_MUL_EN
    S_TWBHI = 3'd4,
`endif
    S_TWB   = 3'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [3:0]         r_op;
  logic [AW-1:0]      r_ra;
  logic [AW-1:0]      r_rb;
  logic [AW-1:0]      r_rc;
  logic [WIDTH-1:0]   r_y;
  logic [c_ZW-1:0]    r_z;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_zero;
  logic               r_err;

  logic [WIDTH-1:0]   w_bus;
  logic [c_SW-1:0]    w_shamt;
  logic [2*WIDTH-1:0] w_dbl;
  logic [2*WIDTH-1:0] w_rot;
  logic [c_ZW-1:0]    w_alu;
  logic               w_op_legal;

  always_comb begin
    w_op_legal = (op <= c_OP_NOT);
`ifdef DATAPATH_SEQ_MUL_EN
    if (op == c_OP_MUL) begin
      w_op_legal = 1'b1;
    end
`endif
  end

  // The single bus carries R[rb] during TY and R[rc] during TZ.
  always_comb begin
    w_bus = (r_state == S_TY) ? r_regs[r_rb] : r_regs[r_rc];
  end

  always_comb begin
    w_shamt = w_bus[c_SW-1:0];
    w_dbl   = {r_y, r_y};
    w_rot   = '0;
    w_alu   = '0;
    case (r_op)
      c_OP_ADD:  w_alu[WIDTH-1:0] = r_y + w_bus;
      c_OP_SUB:  w_alu[WIDTH-1:0] = r_y - w_bus;
      c_OP_AND:  w_alu[WIDTH-1:0] = r_y & w_bus;
      c_OP_OR:   w_alu[WIDTH-1:0] = r_y | w_bus;
      c_OP_SHR:  w_alu[WIDTH-1:0] = r_y >> w_shamt;
      c_OP_SHRA: w_alu[WIDTH-1:0] = $signed(r_y) >>> w_shamt;
      c_OP_SHL:  w_alu[WIDTH-1:0] = r_y << w_shamt;
      c_OP_ROR: begin
        w_rot            = w_dbl >> w_shamt;
        w_alu[WIDTH-1:0] = w_rot[WIDTH-1:0];
      end
      c_OP_ROL: begin
        w_rot            = w_dbl << w_shamt;
        w_alu[WIDTH-1:0] = w_rot[2*WIDTH-1:WIDTH];
      end
      c_OP_NEG:  w_alu[WIDTH-1:0] = -w_bus;
      c_OP_NOT:  w_alu[WIDTH-1:0] = ~w_bus;
`ifdef DATAPATH_SEQ_MUL_EN
      // Low 2W bits of the product of sign-extended operands = signed product.
      c_OP_MUL:  w_alu = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y}) *
                         $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});
`endif
      default:   w_alu = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_op_legal) begin
          w_next = S_TY;
        end
      end
      S_TY: w_next = S_TZ;
      S_TZ: begin
        w_next = S_TWB;
`ifdef DATAPATH_SEQ_MUL_EN
        if (r_op == c_OP_MUL) begin
          w_next = S_TWBHI;
        end
`endif
      end
      S_TWB:   w_next = S_IDLE;
`ifdef DATAPATH_SEQ_MUL_EN
      S_TWBHI: w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_op   <= '0;
      r_ra   <= '0;
      r_rb   <= '0;
      r_rc   <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_zero <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A same-cycle load lands before TY reads the file, so the op sees it.
          if (ld_en) begin
            r_regs[ld_addr] <= ld_data;
          end
          if (start) begin
            if (w_op_legal) begin
              r_op <= op;
              r_ra <= ra;
              r_rb <= rb;
              r_rc <= rc;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_TY: r_y <= w_bus;
        S_TZ: r_z <= w_alu;
        S_TWB: begin
          r_regs[r_ra] <= r_z[WIDTH-1:0];
          r_zero       <= (r_z[WIDTH-1:0] == '0);
        end
`ifdef DATAPATH_SEQ_MUL_EN
        S_TWBHI: begin
          r_hi   <= r_z[2*WIDTH-1:WIDTH];
          r_lo   <= r_z[WIDTH-1:0];
          r_zero <= (r_z == '0);
        end
`endif
        default: ;
      endcase
    end
  end

  assign rd_data = r_regs[rd_addr];
  assign busy    = (r_state != S_IDLE);
`ifdef DATAPATH_SEQ_MUL_EN
  assign done    = (r_state == S_TWB) || (r_state == S_TWBHI);
`else
  assign done    = (r_state == S_TWB);
`endif
  assign err     = r_err;
  assign zero    = r_zero;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_seq
// Brief    : Directed + randomized bench for datapath_seq against a reference
//            model of the register file and opcode semantics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_seq;

`ifdef DATAPATH_SEQ_MUL_EN
  localparam bit c_MUL_EN = 1'b1;
`else
  localparam bit c_MUL_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [3:0]  ra = '0;
  logic [3:0]  rb = '0;
  logic [3:0]  rc = '0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_regs [16];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_zero;

  datapath_seq dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .rc      (rc),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .zero    (zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Operation semantics written from the opcode table, bit-by-bit for shifts.
  function automatic logic [63:0] model_alu(input logic [3:0] o, input logic [31:0] y,
                                            input logic [31:0] b);
    logic [31:0] t;
    int          s;
    longint      p;
    s = int'(b % 32);
    t = y;
    case (o)
      4'd0:  return {32'h0, y + b};
      4'd1:  return {32'h0, y - b};
      4'd2:  return {32'h0, y & b};
      4'd3:  return {32'h0, y | b};
      4'd4:  begin repeat (s) t = {1'b0, t[31:1]};  return {32'h0, t}; end
      4'd5:  begin repeat (s) t = {t[31], t[31:1]}; return {32'h0, t}; end
      4'd6:  begin repeat (s) t = {t[30:0], 1'b0};  return {32'h0, t}; end
      4'd7:  begin repeat (s) t = {t[0], t[31:1]};  return {32'h0, t}; end
      4'd8:  begin repeat (s) t = {t[30:0], t[31]}; return {32'h0, t}; end
      4'd9:  return {32'h0, 32'd0 - b};
      4'd10: return {32'h0, ~b};
      default: begin
        p = longint'($signed(y)) * longint'($signed(b));
        return p;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;
    m_zero = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), {32'h0, rd_data}, {32'h0, m_regs[i]});
    end
    check({tag, "_zero"}, {63'h0, zero}, {63'h0, m_zero});
    check({tag, "_hi"}, {32'h0, hi}, {32'h0, m_hi});
    check({tag, "_lo"}, {32'h0, lo}, {32'h0, m_lo});
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
    m_regs[a] = d;
  endtask

  // Issues one op, jams start/ld/operand inputs while busy, checks timing and result.
  task automatic do_op(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input bit with_ld, input logic [3:0] la,
                       input logic [31:0] ld);
    bit          legal;
    logic [63:0] z;
    legal = (o <= 4'd10) || (c_MUL_EN && o == 4'd11);
    op = o; ra = a; rb = b; rc = c; start = 1'b1;
    if (with_ld) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ld;
      m_regs[la] = ld;
    end
    tick();
    start = 1'b0;
    ld_en = 1'b0;
    if (!legal) begin
      check("illegal_err", {63'h0, err}, 64'd1);
      check("illegal_busy", {63'h0, busy}, 64'd0);
      tick();
      check("illegal_err_drop", {63'h0, err}, 64'd0);
      check("illegal_busy2", {63'h0, busy}, 64'd0);
      return;
    end
    z = model_alu(o, m_regs[b], m_regs[c]);
    for (int cyc = 0; cyc < 3; cyc++) begin
      check("busy_run", {63'h0, busy}, 64'd1);
      check("done_time", {63'h0, done}, (cyc == 2) ? 64'd1 : 64'd0);
      check("err_run", {63'h0, err}, 64'd0);
      if (cyc < 2) begin
        start = 1'b1;
        op = 4'($urandom_range(0, 15));
        ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
        ld_en = 1'b1;
        ld_addr = 4'($urandom);
        ld_data = $urandom;
      end else begin
        start = 1'b0;
        ld_en = 1'b0;
      end
      tick();
    end
    if (c_MUL_EN && o == 4'd11) begin
      m_hi = z[63:32];
      m_lo = z[31:0];
      m_zero = (z == 64'd0);
    end else begin
      m_regs[a] = z[31:0];
      m_zero = (z[31:0] == 32'd0);
    end
    check("idle_busy", {63'h0, busy}, 64'd0);
    check("idle_done", {63'h0, done}, 64'd0);
  endtask

  initial begin
    model_reset();
    clear = 1'b0;
    start = 1'b1;
    ld_en = 1'b1;
    tick();
    tick();
    start = 1'b0;
    ld_en = 1'b0;
    clear = 1'b1;
    check("rst_busy", {63'h0, busy}, 64'd0);
    check("rst_done", {63'h0, done}, 64'd0);
    check("rst_err", {63'h0, err}, 64'd0);
    check_state("rst");

    // Basic add
    load(4'd1, 32'd5);
    load(4'd2, 32'd7);
    do_op(4'd0, 4'd3, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0);
    rd_addr = 4'd3; #1;
    check("add_r3", {32'h0, rd_data}, 64'd12);
    check("add_zero", {63'h0, zero}, 64'd0);
    check_state("add");

    // Arithmetic shift and rotate
    load(4'd1, 32'h8000_0000);
    load(4'd2, 32'd4);
    do_op(4'd5, 4'd4, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0);
    do_op(4'd8, 4'd5, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0);
    rd_addr = 4'd4; #1;
    check("shra_r4", {32'h0, rd_data}, 64'hF800_0000);
    rd_addr = 4'd5; #1;
    check("rol_r5", {32'h0, rd_data}, 64'h0000_0008);
    check_state("shift");

    // Multiply (or illegal without the multiplier)
    load(4'd1, 32'hFFFF_FFFD);
    load(4'd2, 32'd6);
    do_op(4'd11, 4'd7, 4'd1, 4'd2, 1'b0, 4'd0, 32'd0);
    if (c_MUL_EN) begin
      check("mul_hi", {32'h0, hi}, 64'hFFFF_FFFF);
      check("mul_lo", {32'h0, lo}, 64'hFFFF_FFEE);
    end
    check_state("mul");

    // Abort in TZ
    load(4'd3, 32'd9);
    op = 4'd1; ra = 4'd6; rb = 4'd3; rc = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    model_reset();
    check("abort_busy", {63'h0, busy}, 64'd0);
    check("abort_done", {63'h0, done}, 64'd0);
    check_state("abort");
    load(4'd2, 32'd3);
    do_op(4'd1, 4'd6, 4'd3, 4'd2, 1'b0, 4'd0, 32'd0);
    rd_addr = 4'd6; #1;
    check("after_abort_r6", {32'h0, rd_data}, 64'hFFFF_FFFD);

    // Illegal opcode, then in-place SUB to zero
    load(4'd1, 32'h1234_5678);
    do_op(4'd13, 4'd1, 4'd1, 4'd1, 1'b0, 4'd0, 32'd0);
    do_op(4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 4'd0, 32'd0);
    rd_addr = 4'd1; #1;
    check("sub_self_r1", {32'h0, rd_data}, 64'd0);
    check("sub_self_zero", {63'h0, zero}, 64'd1);

    // Load and start in the same cycle: op must see loaded value
    do_op(4'd0, 4'd8, 4'd9, 4'd9, 1'b1, 4'd9, 32'd21);
    rd_addr = 4'd8; #1;
    check("ld_start_r8", {32'h0, rd_data}, 64'd42);
    check_state("ldstart");

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 1) == 1) load(4'($urandom), d);
      do_op(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
            bit'($urandom_range(0, 1)), 4'($urandom), $urandom);
      check_state("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
